level_sequencer: RTL and testbench

- Parametrised game-level controller for the symbol-counter game. Tracks the current level and derives the symbol-generation period from it. Drives the symbol tick strobe plus a preliminary warning ahead of each tick.
- Sits between the score/compare logic, which requests level-ups, and the symbol generator and display, which consume the ticks, level number and new-level strobe.
- Generalises level control with: configurable widths and limits, saturation at max level and min period, a selectable speed-up mode, a run/pause control and a synchronous game restart.

---
 rtl/level_pkg.sv | 16 +
 rtl/sym_tick_gen.sv | 60 ++++++
 rtl/level_sequencer.sv | 107 ++++++++++
 tb/tb_level_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/level_pkg.sv
// Shared defaults and width helpers for the symbol-counter game level controller.
package level_pkg;

  localparam int unsigned DEF_MAX_LEVEL     = 15;
  localparam int unsigned DEF_PERIOD_W      = 32;
  localparam int unsigned DEF_INIT_PERIOD   = 100_000_000;
  localparam int unsigned DEF_STEP          = 50_000;
  localparam int unsigned DEF_MIN_PERIOD    = 10_000_000;
  localparam int unsigned DEF_PRELIM_CYCLES = 5_000_000;

  // Bits needed to hold levels 0..max_level.
  function automatic int unsigned lvl_width(input int unsigned max_level);
    return $clog2(max_level + 1);
  endfunction

endpackage

// File: rtl/sym_tick_gen.sv
// Free-running period counter: one-cycle symbol tick per period plus a
// preliminary window covering the last PRELIM_CYCLES counts before the wrap.
module sym_tick_gen #(
  parameter int unsigned PERIOD_W      = 32,
  parameter int unsigned PRELIM_CYCLES = 5_000_000
) (
  input  logic                Clk100M,
  input  logic                Rst_n,
  input  logic                clr,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic                symTick,
  output logic                prelimSig
);

  logic [PERIOD_W-1:0] count_q, count_d;
  logic [PERIOD_W-1:0] last_c;
  logic [PERIOD_W-1:0] remain_c;
  logic                tick_q, tick_d;
  logic                prelim_q, prelim_d;

  assign last_c = period - PERIOD_W'(1);

  // Prelim is evaluated on the post-update count so it lines up with count_q.
  always_comb begin
    count_d  = count_q;
    tick_d   = 1'b0;
    prelim_d = prelim_q;
    remain_c = '0;
    if (clr) begin
      count_d  = '0;
      prelim_d = 1'b0;
    end else if (run) begin
      if (count_q >= last_c) begin
        count_d = '0;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + PERIOD_W'(1);
      end
      remain_c = last_c - count_d;
      prelim_d = (remain_c != '0) && (remain_c <= PERIOD_W'(PRELIM_CYCLES));
    end
  end

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      count_q  <= '0;
      tick_q   <= 1'b0;
      prelim_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      tick_q   <= tick_d;
      prelim_q <= prelim_d;
    end
  end

  assign symTick   = tick_q;
  assign prelimSig = prelim_q;

endmodule

// File: rtl/level_sequencer.sv
// Game level controller: tracks the level, derives the symbol period from it
// and drives the symbol tick generator.
module level_sequencer
  import level_pkg::*;
#(
  parameter int unsigned MAX_LEVEL     = DEF_MAX_LEVEL,
  parameter int unsigned PERIOD_W      = DEF_PERIOD_W,
  parameter int unsigned INIT_PERIOD   = DEF_INIT_PERIOD,
  parameter int unsigned STEP          = DEF_STEP,
  parameter int unsigned MIN_PERIOD    = DEF_MIN_PERIOD,
  parameter int unsigned PRELIM_CYCLES = DEF_PRELIM_CYCLES,
  parameter bit          LINEAR_MODE   = 1'b1,
  localparam int unsigned LVL_W        = lvl_width(MAX_LEVEL)
) (
  input  logic                Clk100M,
  input  logic                Rst_n,
  input  logic                restart,
  input  logic                run,
  input  logic                incLevel,
  output logic [LVL_W-1:0]    curLevel,
  output logic [PERIOD_W-1:0] symGenMax,
  output logic                newLevel,
  output logic                atMax,
  output logic                symTick,
  output logic                prelimSig
);

  localparam int unsigned AW = PERIOD_W + LVL_W + 1;

  logic [LVL_W-1:0]    cur_level_q, cur_level_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                new_level_q, new_level_d;
  logic                start_pend_q, start_pend_d;

  logic                at_max_c;
  logic                lvl_up_c;
  logic                tick_clr_c;
  logic [AW-1:0]       dec_c;
  logic [AW-1:0]       diff_c;
  logic [PERIOD_W-1:0] next_period_c;

  assign at_max_c   = (cur_level_q == LVL_W'(MAX_LEVEL));
  assign lvl_up_c   = incLevel && !at_max_c;
  assign tick_clr_c = restart || lvl_up_c;

  // Extra headroom bit makes an over-large decrement show up as a set MSB.
  assign dec_c  = LINEAR_MODE ? (AW'(STEP) * AW'(cur_level_q)) : AW'(STEP);
  assign diff_c = AW'(period_q) - dec_c;
  assign next_period_c = (diff_c[AW-1] || (diff_c < AW'(MIN_PERIOD)))
                         ? PERIOD_W'(MIN_PERIOD) : diff_c[PERIOD_W-1:0];

  always_comb begin
    cur_level_d  = cur_level_q;
    period_d     = period_q;
    new_level_d  = 1'b0;
    start_pend_d = start_pend_q;
    if (restart) begin
      cur_level_d  = LVL_W'(1);
      period_d     = PERIOD_W'(INIT_PERIOD);
      new_level_d  = 1'b1;
      start_pend_d = 1'b0;
    end else begin
      if (start_pend_q) begin
        new_level_d  = 1'b1;
        start_pend_d = 1'b0;
      end
      if (lvl_up_c) begin
        cur_level_d = cur_level_q + LVL_W'(1);
        period_d    = next_period_c;
        new_level_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      cur_level_q  <= LVL_W'(1);
      period_q     <= PERIOD_W'(INIT_PERIOD);
      new_level_q  <= 1'b0;
      start_pend_q <= 1'b1;
    end else begin
      cur_level_q  <= cur_level_d;
      period_q     <= period_d;
      new_level_q  <= new_level_d;
      start_pend_q <= start_pend_d;
    end
  end

  sym_tick_gen #(
    .PERIOD_W      (PERIOD_W),
    .PRELIM_CYCLES (PRELIM_CYCLES)
  ) u_tick (
    .Clk100M   (Clk100M),
    .Rst_n     (Rst_n),
    .clr       (tick_clr_c),
    .run       (run),
    .period    (period_q),
    .symTick   (symTick),
    .prelimSig (prelimSig)
  );

  assign curLevel  = cur_level_q;
  assign symGenMax = period_q;
  assign newLevel  = new_level_q;
  assign atMax     = at_max_c;

endmodule

// File: tb/tb_level_sequencer.sv
// Scoreboard bench for level_sequencer: linear-mode and fixed-step instances.
module tb_level_sequencer;

  localparam int unsigned LVL_W = 3;
  localparam int unsigned PW    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic restart1 = 1'b0, run1 = 1'b1, incLevel1 = 1'b0;
  logic restart2 = 1'b0, run2 = 1'b1, incLevel2 = 1'b0;

  logic [LVL_W-1:0] curLevel1, curLevel2;
  logic [PW-1:0]    symGenMax1, symGenMax2;
  logic newLevel1, atMax1, symTick1, prelimSig1;
  logic newLevel2, atMax2, symTick2, prelimSig2;

  level_sequencer #(
    .MAX_LEVEL(4), .PERIOD_W(PW), .INIT_PERIOD(20), .STEP(3),
    .MIN_PERIOD(8), .PRELIM_CYCLES(2), .LINEAR_MODE(1'b1)
  ) u_lin (
    .Clk100M(clk), .Rst_n(rst_n), .restart(restart1), .run(run1),
    .incLevel(incLevel1), .curLevel(curLevel1), .symGenMax(symGenMax1),
    .newLevel(newLevel1), .atMax(atMax1), .symTick(symTick1),
    .prelimSig(prelimSig1)
  );

  level_sequencer #(
    .MAX_LEVEL(4), .PERIOD_W(PW), .INIT_PERIOD(20), .STEP(3),
    .MIN_PERIOD(8), .PRELIM_CYCLES(2), .LINEAR_MODE(1'b0)
  ) u_step (
    .Clk100M(clk), .Rst_n(rst_n), .restart(restart2), .run(run2),
    .incLevel(incLevel2), .curLevel(curLevel2), .symGenMax(symGenMax2),
    .newLevel(newLevel2), .atMax(atMax2), .symTick(symTick2),
    .prelimSig(prelimSig2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int level;
    int period;
    int at_max;
  } nl_t;

  nl_t exp_nl1[$];
  nl_t exp_nl2[$];
  int  exp_tick[$];
  nl_t mon_e;
  int  mon_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_nl1(input int c, input int l, input int p, input int m);
    nl_t e;
    e.cyc = c; e.level = l; e.period = p; e.at_max = m;
    exp_nl1.push_back(e);
  endtask

  task automatic push_nl2(input int c, input int l, input int p, input int m);
    nl_t e;
    e.cyc = c; e.level = l; e.period = p; e.at_max = m;
    exp_nl2.push_back(e);
  endtask

  // Ticks for a segment whose count is 0 after edge s and which is cleared at edge s+len.
  task automatic push_ticks(input int s, input int per, input int len);
    for (int k = 1; k * per <= len - 1; k++) exp_tick.push_back(s + k * per);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse(input bit i1, input bit i2, input bit rs);
    incLevel1 = i1;
    incLevel2 = i2;
    restart1  = rs;
    @(negedge clk);
    incLevel1 = 1'b0;
    incLevel2 = 1'b0;
    restart1  = 1'b0;
  endtask

  // Monitor: pops an expectation whenever a strobe is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (newLevel1) begin
        if (exp_nl1.size() == 0) chk("nl1_unexpected_cycle", cyc, -1);
        else begin
          mon_e = exp_nl1.pop_front();
          chk("nl1_cycle", cyc, mon_e.cyc);
          chk("nl1_level", int'(curLevel1), mon_e.level);
          chk("nl1_period", int'(symGenMax1), mon_e.period);
          chk("nl1_atMax", int'(atMax1), mon_e.at_max);
        end
      end
      if (newLevel2) begin
        if (exp_nl2.size() == 0) chk("nl2_unexpected_cycle", cyc, -1);
        else begin
          mon_e = exp_nl2.pop_front();
          chk("nl2_cycle", cyc, mon_e.cyc);
          chk("nl2_level", int'(curLevel2), mon_e.level);
          chk("nl2_period", int'(symGenMax2), mon_e.period);
          chk("nl2_atMax", int'(atMax2), mon_e.at_max);
        end
      end
      if (symTick1) begin
        if (exp_tick.size() == 0) chk("tick_unexpected_cycle", cyc, -1);
        else begin
          mon_t = exp_tick.pop_front();
          chk("tick_cycle", cyc, mon_t);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, r1, x, s, s3, p, q;

    @(negedge clk);
    chk("rst_level", int'(curLevel1), 1);
    chk("rst_period", int'(symGenMax1), 20);
    chk("rst_newLevel", int'(newLevel1), 0);
    chk("rst_symTick", int'(symTick1), 0);
    chk("rst_prelim", int'(prelimSig1), 0);
    chk("rst_atMax", int'(atMax1), 0);
    chk("rst_period2", int'(symGenMax2), 20);

    // Level 1, free running
    wait_until(3);
    r0 = cyc;
    push_nl1(r0 + 1, 1, 20, 0);
    push_nl2(r0 + 1, 1, 20, 0);
    push_ticks(r0, 20, 70);
    rst_n = 1'b1;
    wait_until(r0 + 16); chk("prelim_cnt16", int'(prelimSig1), 0);
    wait_until(r0 + 17); chk("prelim_cnt17", int'(prelimSig1), 1);
    wait_until(r0 + 18); chk("prelim_cnt18", int'(prelimSig1), 1);
    wait_until(r0 + 19); chk("prelim_cnt19", int'(prelimSig1), 0);
    wait_until(r0 + 20); chk("prelim_tick_cycle", int'(prelimSig1), 0);

    // Three level-ups: linear 17/11/8(clamped), fixed-step 17/14/11
    wait_until(r0 + 69); x = cyc;
    push_nl1(x + 1, 2, 17, 0); push_nl2(x + 1, 2, 17, 0);
    push_ticks(x + 1, 17, 30);
    pulse(1'b1, 1'b1, 1'b0);
    wait_until(x + 30); x = cyc;
    push_nl1(x + 1, 3, 11, 0); push_nl2(x + 1, 3, 14, 0);
    push_ticks(x + 1, 11, 30);
    pulse(1'b1, 1'b1, 1'b0);
    wait_until(x + 30); x = cyc; s3 = x + 1;
    push_nl1(s3, 4, 8, 1); push_nl2(s3, 4, 11, 1);
    push_ticks(s3, 8, 33);
    pulse(1'b1, 1'b1, 1'b0);

    // Level-up request at max level is ignored
    wait_until(s3 + 20);
    pulse(1'b1, 1'b0, 1'b0);
    wait_until(s3 + 23);
    chk("max_level_hold", int'(curLevel1), 4);
    chk("max_period_hold", int'(symGenMax1), 8);
    chk("max_atMax", int'(atMax1), 1);

    // Pause for 10 cycles at count 5
    p = s3 + 37;
    wait_until(p);
    chk("prelim_cnt5", int'(prelimSig1), 1);
    run1 = 1'b0;
    wait_until(p + 5);
    chk("pause_prelim_hold", int'(prelimSig1), 1);
    chk("pause_no_tick", int'(symTick1), 0);
    wait_until(p + 10);
    exp_tick.push_back(p + 13);
    exp_tick.push_back(p + 21);
    exp_tick.push_back(p + 29);
    run1 = 1'b1;
    wait_until(p + 11); chk("resume_prelim_cnt6", int'(prelimSig1), 1);
    wait_until(p + 12); chk("resume_prelim_cnt7", int'(prelimSig1), 0);

    // Restart, climb to level 3, then restart together with a level-up
    q = p + 30;
    wait_until(q);
    push_nl1(q + 1, 1, 20, 0);
    push_ticks(q + 1, 20, 30);
    pulse(1'b0, 1'b0, 1'b1);
    wait_until(q + 30); x = cyc;
    push_nl1(x + 1, 2, 17, 0);
    push_ticks(x + 1, 17, 30);
    pulse(1'b1, 1'b0, 1'b0);
    wait_until(x + 30); x = cyc;
    push_nl1(x + 1, 3, 11, 0);
    push_ticks(x + 1, 11, 30);
    pulse(1'b1, 1'b0, 1'b0);
    wait_until(x + 30); x = cyc; s = x + 1;
    push_nl1(s, 1, 20, 0);
    push_ticks(s, 20, 30);
    pulse(1'b1, 1'b0, 1'b1);
    wait_until(s + 16); chk("restart_prelim_cnt16", int'(prelimSig1), 0);
    wait_until(s + 17); chk("restart_prelim_cnt17", int'(prelimSig1), 1);

    // Asynchronous reset mid-period at level 2, count 12
    wait_until(s + 29); x = cyc; s = x + 1;
    push_nl1(s, 2, 17, 0);
    pulse(1'b1, 1'b0, 1'b0);
    wait_until(s + 12);
    chk("pre_reset_level", int'(curLevel1), 2);
    chk("pre_reset_period", int'(symGenMax1), 17);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_level", int'(curLevel1), 1);
    chk("async_rst_period", int'(symGenMax1), 20);
    chk("async_rst_newLevel", int'(newLevel1), 0);
    chk("async_rst_symTick", int'(symTick1), 0);
    chk("async_rst_prelim", int'(prelimSig1), 0);
    chk("async_rst_atMax", int'(atMax1), 0);
    chk("async_rst_level2", int'(curLevel2), 1);
    chk("async_rst_period2", int'(symGenMax2), 20);
    repeat (3) @(negedge clk);
    r1 = cyc;
    push_nl1(r1 + 1, 1, 20, 0);
    push_nl2(r1 + 1, 1, 20, 0);
    rst_n = 1'b1;
    wait_until(r1 + 10);

    chk("pending_newLevel1", exp_nl1.size(), 0);
    chk("pending_newLevel2", exp_nl2.size(), 0);
    chk("pending_ticks", exp_tick.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
